para_selector: RTL and testbench

Upstream operator-input stage for the pulse generator's parameter path. Takes two raw push-buttons (up/down) and produces the 4-bit parameter index that the parameter decoder converts into the two-character display code. Each button is synchronised and debounced, and supports auto-repeat. The index steps through 0..PARA_COUNT-1 with wrap-around, and every change is flagged with a one-cycle strobe.

---
 rtl/para_pkg.sv | 19 +
 rtl/btn_debounce.sv | 78 +++++++
 rtl/para_selector.sv | 71 +++++++
 tb/tb_para_selector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// Shared definitions for the parameter path: index width, index count and wrap helpers.
package para_pkg;

    localparam int PARA_COUNT = 12;
    localparam int PARA_W     = 4;

    typedef logic [PARA_W-1:0] para_idx_t;

    localparam para_idx_t PARA_LAST = para_idx_t'(PARA_COUNT - 1);

    function automatic para_idx_t para_inc(input para_idx_t idx);
        return (idx == PARA_LAST) ? '0 : idx + para_idx_t'(1);
    endfunction

    function automatic para_idx_t para_dec(input para_idx_t idx);
        return (idx == '0) ? PARA_LAST : idx - para_idx_t'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce filter and hold/auto-repeat
// step generator.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic step
);

    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);

    logic [1:0]       sync_reg;
    logic             level_reg, level_next;
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             step_reg, step_next;

    always_comb begin
        level_next    = level_reg;
        deb_cnt_next  = '0;
        hold_cnt_next = '0;
        step_next     = 1'b0;

        if (sync_reg[1] != level_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
                level_next = sync_reg[1];
            end else begin
                deb_cnt_next = deb_cnt_reg + DEB_W'(1);
            end
        end

        // The step is issued on the edge where the count would reach 1, so each pulse
        // lands HOLD/REPEAT-1 cycles after the previous one.
        if (level_next) begin
            if (!level_reg) begin
                hold_cnt_next = HOLD_LOAD;
                step_next     = 1'b1;
            end else if (hold_cnt_reg == CNT_TWO) begin
                hold_cnt_next = REPEAT_LOAD;
                step_next     = 1'b1;
            end else begin
                hold_cnt_next = hold_cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg     <= '0;
            level_reg    <= 1'b0;
            deb_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            step_reg     <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], btn};
            level_reg    <= level_next;
            deb_cnt_reg  <= deb_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            step_reg     <= step_next;
        end
    end

    assign level = level_reg;
    assign step  = step_reg;

endmodule

// File: rtl/para_selector.sv
// Operator input stage: two debounced, auto-repeating buttons step a wrapping
// parameter index and flag each change with a one-cycle strobe.
module para_selector
    import para_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 2500000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              BTN_UP,
    input  logic              BTN_DN,
    output logic [PARA_W-1:0] PARA_SEL,
    output logic              PARA_CHANGED
);

    logic [1:0] btns;
    logic [1:0] steps;
    logic [1:0] level_unused;

    assign btns = {BTN_DN, BTN_UP};

    // Bit 0 is the up channel, bit 1 the down channel.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_btn (
            .clk  (CLOCK),
            .rst  (RESET),
            .btn  (btns[gi]),
            .level(level_unused[gi]),
            .step (steps[gi])
        );
    end

    para_idx_t para_reg, para_next;
    logic      changed_reg, changed_next;

    always_comb begin
        para_next    = para_reg;
        changed_next = 1'b0;
        case (steps)
            2'b01: begin
                para_next    = para_inc(para_reg);
                changed_next = 1'b1;
            end
            2'b10: begin
                para_next    = para_dec(para_reg);
                changed_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            para_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            para_reg    <= para_next;
            changed_reg <= changed_next;
        end
    end

    assign PARA_SEL     = para_reg;
    assign PARA_CHANGED = changed_reg;

endmodule

// File: tb/tb_para_selector.sv
// Randomised and directed bench for para_selector against a cycle-level behavioural
// model built from press timing (debounce run length, press age, wrap arithmetic).
module tb_para_selector;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;
    localparam int NP   = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [3:0] para_sel;
    logic       para_changed;

    always #5 clk = ~clk;

    para_selector #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .BTN_UP      (btn_up),
        .BTN_DN      (btn_dn),
        .PARA_SEL    (para_sel),
        .PARA_CHANGED(para_changed)
    );

    int checks = 0;
    int errors = 0;
    int chg_count = 0;
    bit cmp_en = 1'b0;

    // Model state: index, strobe, and per button (0=up, 1=down) sync stages,
    // debounce run length, level, cycles since rise, and step due at next edge.
    int m_sel;
    bit m_chg;
    bit s1[2], s2[2], lvl[2], pend[2];
    int run[2], age[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_rep(input int a);
        if (a == HOLD - 1) return 1'b1;
        if (a > HOLD - 1 && ((a - (HOLD - 1)) % (REP - 1)) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_sel = 0;
        m_chg = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s1[b] = 1'b0; s2[b] = 1'b0; lvl[b] = 1'b0; pend[b] = 1'b0;
            run[b] = 0;   age[b] = 0;
        end
    endtask

    task automatic model_step();
        bit raw[2];
        bit rose;
        raw[0] = btn_up;
        raw[1] = btn_dn;
        m_chg = pend[0] ^ pend[1];
        if (pend[0] && !pend[1])      m_sel = (m_sel + 1) % NP;
        else if (pend[1] && !pend[0]) m_sel = (m_sel + NP - 1) % NP;
        for (int b = 0; b < 2; b++) begin
            rose = 1'b0;
            if (s2[b] != lvl[b]) begin
                run[b]++;
                if (run[b] == DEB) begin
                    lvl[b] = s2[b];
                    run[b] = 0;
                    rose   = lvl[b];
                end
            end else begin
                run[b] = 0;
            end
            if (rose) begin
                age[b]  = 0;
                pend[b] = 1'b1;
            end else if (lvl[b]) begin
                age[b]++;
                pend[b] = is_rep(age[b]);
            end else begin
                pend[b] = 1'b0;
            end
            s2[b] = s1[b];
            s1[b] = raw[b];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_sel", para_sel, 0);
        check("reset_chg", para_changed, 0);
        ticks(2);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_sel", para_sel, m_sel);
            check("model_chg", para_changed, m_chg);
            check("sel_range", (para_sel < 4'd12) ? 1 : 0, 1);
            if (para_changed) chg_count++;
        end
    end

    initial begin
        bit reached;
        int up_dur, dn_dur;

        do_reset();
        cmp_en = 1'b1;

        // Single 30-cycle press: steps at edges 7, 22, 29, 36.
        btn_up = 1'b1;
        ticks(6);
        check("t1_before", para_sel, 0);
        tick();
        check("t1_first_sel", para_sel, 1);
        check("t1_first_chg", para_changed, 1);
        check("t1_model_first", m_sel, 1);
        tick();
        check("t1_strobe_len", para_changed, 0);
        ticks(14);
        check("t1_second_sel", para_sel, 2);
        check("t1_model_second", m_sel, 2);
        ticks(8);
        btn_up = 1'b0;
        ticks(40);
        check("t1_final", para_sel, 4);

        // Wrap both directions.
        do_reset();
        btn_dn = 1'b1; ticks(10); btn_dn = 1'b0; ticks(20);
        check("t2_wrap_dn", para_sel, 11);
        btn_up = 1'b1; ticks(10); btn_up = 1'b0; ticks(20);
        check("t2_wrap_up", para_sel, 0);

        // Bouncing press, then stable high.
        do_reset();
        chg_count = 0;
        for (int w = 1; w <= 3; w++) begin
            btn_up = 1'b1; ticks(w);
            btn_up = 1'b0; ticks(3);
        end
        btn_up = 1'b1;
        ticks(6);
        check("t3_no_early", para_sel, 0);
        tick();
        check("t3_step", para_sel, 1);
        ticks(3);
        btn_up = 1'b0;
        ticks(20);
        check("t3_count", chg_count, 1);

        // Both buttons together.
        do_reset();
        btn_up = 1'b1; ticks(10); btn_up = 1'b0; ticks(20);
        chg_count = 0;
        btn_up = 1'b1; btn_dn = 1'b1;
        ticks(40);
        btn_up = 1'b0; btn_dn = 1'b0;
        ticks(20);
        check("t4_sel", para_sel, 1);
        check("t4_count", chg_count, 0);

        // Reset in the middle of a hold.
        do_reset();
        btn_up = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            tick();
            if (para_sel == 4'd3) reached = 1'b1;
        end
        check("t5_reach3", reached ? 1 : 0, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_async_sel", para_sel, 0);
        ticks(2);
        rst = 1'b0;
        ticks(6);
        check("t5_wait", para_sel, 0);
        tick();
        check("t5_fresh_sel", para_sel, 1);
        check("t5_fresh_chg", para_changed, 1);
        btn_up = 1'b0;
        ticks(30);

        // Full sweep of twelve presses.
        do_reset();
        chg_count = 0;
        for (int i = 0; i < NP; i++) begin
            btn_up = 1'b1; ticks(10); btn_up = 1'b0; ticks(15);
            check("t6_sweep", para_sel, (i + 1) % NP);
        end
        check("t6_count", chg_count, 12);

        // Random button activity with occasional resets.
        do_reset();
        up_dur = 0;
        dn_dur = 0;
        for (int n = 0; n < 4000; n++) begin
            if (up_dur == 0) begin
                btn_up = $urandom_range(0, 1) == 1;
                up_dur = $urandom_range(1, 60);
            end
            if (dn_dur == 0) begin
                btn_dn = $urandom_range(0, 2) == 0;
                dn_dur = $urandom_range(1, 60);
            end
            up_dur--;
            dn_dur--;
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                model_reset();
                ticks($urandom_range(1, 3));
                rst = 1'b0;
            end
            tick();
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        ticks(30);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
